mdu_core: RTL and testbench
===========================

# mdu_core

Iterative multiply/divide execution core with architectural HI/LO registers. It is the responder on the `start`/`busy` side of the MDU dispatch interface. The MDU dispatch controller arbitrates two issue slots, selects one operand/op set, and pulses `start` when `busy` is low. This core runs the operation, owns HI/LO, returns the 32-bit MUL product, and rolls back HI/LO when the pipeline recovers from misspeculation.

## Interface
- Parameters: none.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `a` in 32: operand A; MTHI/MTLO source.
- `b` in 32: operand B; divisor.
- `MDUOp` in 4: opcode from `mdu_pkg`.
- `start` in 1: request; accepted only when `busy`=0.
- `mt_en` in 1: qualifies MTHI/MTLO writes.
- `highReg` out 32: HI.
- `lowReg` out 32: LO.
- `mul_result` out 32: low 32 bits of the last MUL product.
- `busy` out 1: multi-cycle operation in flight; registered.
- `recover` in 1: flush and roll back.
- `recover_num` in 2: number of completed HI/LO writes to undo.

## Operation
- Opcodes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MUL=9. Codes 10–15 are treated as NOP.
- Accept: `start`=1, `busy`=0, `recover`=0 in cycle T0.
- MTHI/MTLO: on accept with `mt_en`=1, HI or LO is written from `a` at the T0 edge. `busy` stays 0. With `mt_en`=0 the op is ignored.
- MFHI/MFLO/NOP: no state change.
- MULT/MULTU: signed or unsigned 32x32→64 product. HI gets the upper 32 bits, LO the lower 32 bits.
- MUL: signed product, low 32 bits go to `mul_result`. HI/LO are untouched.
- DIV/DIVU: radix-2 restoring division on magnitudes, then sign fixup. LO gets the quotient (truncated toward zero). HI gets the remainder, whose sign follows the dividend.
- Divide by zero, both signednesses: HI=`a`, LO=0xFFFFFFFF.
- History buffer:
  - Every HI/LO write (MT*, MULT*, DIV*) pushes the old {HI,LO} into a 2-entry LIFO.
  - The older entry is dropped when full. The count saturates at 2.
- Recover, on a cycle with `recover`=1:
  - Any in-flight op is aborted; no HI/LO or `mul_result` write from it.
  - `busy` is 0 in the next cycle.
  - min(`recover_num`, count) entries are popped; the last popped entry becomes HI/LO. `recover_num`=3 is treated as 2.
  - `start` is ignored in the same cycle.
- States:
  - IDLE → MUL_RUN on an accepted MULT, MULTU or MUL.
  - IDLE → DIV_RUN on an accepted DIV or DIVU.
  - MUL_RUN and DIV_RUN → IDLE on completion or on `recover`.

## Timing
- Reset values: `highReg`=0, `lowReg`=0, `mul_result`=0, `busy`=0, history count=0, state IDLE.
- MULT/MULTU/MUL:
  - `busy`=1 in T1..T3 (3-stage 16x16 partial-product pipeline).
  - The result is written at the T3 edge and is visible from T4, together with `busy`=0.
- DIV/DIVU:
  - `busy`=1 in T1..T34 (32 iterations, one sign-fix cycle, one writeback cycle).
  - The result is visible from T35.
- MT*: the new value is visible at T1.
- Back-to-back: a new accept is legal in the first cycle `busy`=0.
- `start` while `busy`=1 is ignored and causes no error.
- `recover` on the completion cycle wins: the completion is discarded and HI/LO are restored.
- `reset` overrides `recover` and `start`.
- `mul_result` holds its value until the next MUL completes.

## Configuration
- `MDU_DIV_ZERO_FAST_EN` defined: DIV/DIVU with `b`=0 completes without a busy period. HI=`a` and LO=0xFFFFFFFF are written at the T0 edge, and `busy` stays 0.
- Undefined: a divide by zero takes the full 34 busy cycles and produces the same HI/LO values.

## Structure
- `mdu_pkg` holds:
  - the 4-bit op enum `mdu_op_t`;
  - `MDU_MUL_LAT`=3 and `MDU_DIV_LAT`=34;
  - the state enum `mdu_state_t` (IDLE, MUL_RUN, DIV_RUN).
- Sub-module `mdu_div_radix2` covers the iteration counter, partial-remainder/quotient registers, sign fixup, a `done` pulse and an `abort` input.
- The multiply pipeline, history LIFO and FSM stay in `mdu_core`.

## Test plan
- Reset, then MULT `a`=0xFFFFFFFF, `b`=2 → `busy` high 3 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV `a`=-7, `b`=2 → `busy` high 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU `a`=100, `b`=0 → HI=0x64, LO=0xFFFFFFFF after 34 busy cycles without the macro, and at T1 with no busy cycle with it.
- MTHI 0x11 then MTLO 0x22 → HI=0x11, LO=0x22. Then start DIV and assert `recover` with `recover_num`=1 at T10 → `busy` low at T11, HI=0x11, LO=0 (MTLO undone).
- MUL 3×5 → `mul_result`=15, HI/LO unchanged. `start` while `busy` is ignored. `recover_num`=2 with count=1 restores only 1 entry.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared MDU opcode and state encodings, operation latencies and a magnitude helper.
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MUL   = 4'd9
    } mdu_op_t;

    localparam int unsigned MDU_MUL_LAT = 3;
    localparam int unsigned MDU_DIV_LAT = 34;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN
    } mdu_state_t;

    function automatic logic [31:0] mdu_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_radix2.sv
// Radix-2 restoring divider on operand magnitudes with a final sign-fix cycle.
// done pulses for one cycle once quotient/remainder are valid; abort drops any run.
module mdu_div_radix2
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {PH_IDLE, PH_ITER, PH_FIX, PH_DONE} phase_t;

    phase_t      phase;
    logic [4:0]  iter;
    logic [31:0] rem, quot, dvsr, dvnd_raw;
    logic        q_neg, r_neg, dvsr_zero;
    logic [32:0] rem_sh, diff;

    // quot doubles as the dividend shift register: its MSB feeds the partial remainder
    always_comb begin
        rem_sh = {rem, quot[31]};
        diff   = rem_sh - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            phase <= PH_IDLE;
            done  <= 1'b0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        rem       <= '0;
                        quot      <= mdu_abs(dividend, is_signed);
                        dvsr      <= mdu_abs(divisor, is_signed);
                        q_neg     <= is_signed & (dividend[31] ^ divisor[31]);
                        r_neg     <= is_signed & dividend[31];
                        dvsr_zero <= (divisor == '0);
                        dvnd_raw  <= dividend;
                        iter      <= '0;
                        phase     <= PH_ITER;
                    end
                end
                PH_ITER: begin
                    if (!diff[32]) begin
                        rem  <= diff[31:0];
                        quot <= {quot[30:0], 1'b1};
                    end else begin
                        rem  <= rem_sh[31:0];
                        quot <= {quot[30:0], 1'b0};
                    end
                    iter <= iter + 5'd1;
                    if (iter == 5'(MDU_DIV_LAT - 3))
                        phase <= PH_FIX;
                end
                PH_FIX: begin
                    if (dvsr_zero) begin
                        quotient  <= '1;
                        remainder <= dvnd_raw;
                    end else begin
                        quotient  <= q_neg ? (~quot + 32'd1) : quot;
                        remainder <= r_neg ? (~rem + 32'd1) : rem;
                    end
                    done  <= 1'b1;
                    phase <= PH_DONE;
                end
                PH_DONE: begin
                    done  <= 1'b0;
                    phase <= PH_IDLE;
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mdu_core.sv
// Iterative multiply/divide core owning HI/LO with a 2-deep rollback history.
// Optional MDU_DIV_ZERO_FAST_EN: divide by zero writes HI/LO at accept with no busy period.
module mdu_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    input  logic        mt_en,
    output logic [31:0] highReg,
    output logic [31:0] lowReg,
    output logic [31:0] mul_result,
    output logic        busy,
    input  logic        recover,
    input  logic [1:0]  recover_num
);

    mdu_state_t  state;
    mdu_op_t     op;
    logic        accept, is_mul_op, is_div_op, div_fast, div_start, div_done, mul_last;
    logic [31:0] div_q, div_r;
    logic [1:0]  mul_stage;
    logic [31:0] mul_a, mul_b;
    logic        mul_neg, mul_only;
    logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
    logic [63:0] pp_sum, mul_prod;
    logic [63:0] hist [2];
    logic [1:0]  hist_cnt, rec_req, rec_n;
    logic        hl_wr;
    logic [63:0] hl_new;

    assign op        = mdu_op_t'(MDUOp);
    assign accept    = start & ~busy & ~recover;
    assign is_mul_op = op inside {MULT, MULTU, MUL};
    assign is_div_op = op inside {DIV, DIVU};
`ifdef MDU_DIV_ZERO_FAST_EN
    assign div_fast  = (b == '0);
`else
    assign div_fast  = 1'b0;
`endif
    assign div_start = accept & is_div_op & ~div_fast;
    assign mul_last  = (state == MUL_RUN) && (mul_stage == 2'(MDU_MUL_LAT - 1));
    assign pp_sum    = {32'b0, pp_ll} + {16'b0, pp_lh, 16'b0} + {16'b0, pp_hl, 16'b0} + {pp_hh, 32'b0};

    always_comb begin
        rec_req = (recover_num == 2'd3) ? 2'd2 : recover_num;
        rec_n   = (rec_req > hist_cnt) ? hist_cnt : rec_req;
    end

    always_comb begin
        hl_wr  = 1'b0;
        hl_new = {highReg, lowReg};
        if (accept && mt_en && op == MTHI) begin
            hl_wr  = 1'b1;
            hl_new = {a, lowReg};
        end else if (accept && mt_en && op == MTLO) begin
            hl_wr  = 1'b1;
            hl_new = {highReg, a};
        end else if (accept && is_div_op && div_fast) begin
            hl_wr  = 1'b1;
            hl_new = {a, 32'hFFFF_FFFF};
        end else if (mul_last && !mul_only) begin
            hl_wr  = 1'b1;
            hl_new = mul_prod;
        end else if (state == DIV_RUN && div_done) begin
            hl_wr  = 1'b1;
            hl_new = {div_r, div_q};
        end
    end

    mdu_div_radix2 u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (recover),
        .is_signed (op == DIV),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            highReg    <= '0;
            lowReg     <= '0;
            mul_result <= '0;
            hist_cnt   <= '0;
            mul_stage  <= '0;
        end else if (recover) begin
            // Abort wins over any completion this cycle; restore the deepest popped entry
            state <= IDLE;
            busy  <= 1'b0;
            case (rec_n)
                2'd1: begin
                    {highReg, lowReg} <= hist[0];
                    hist[0]           <= hist[1];
                    hist_cnt          <= hist_cnt - 2'd1;
                end
                2'd2: begin
                    {highReg, lowReg} <= hist[1];
                    hist_cnt          <= hist_cnt - 2'd2;
                end
                default: ;
            endcase
        end else begin
            if (hl_wr) begin
                hist[1]           <= hist[0];
                hist[0]           <= {highReg, lowReg};
                {highReg, lowReg} <= hl_new;
                if (hist_cnt != 2'd2)
                    hist_cnt <= hist_cnt + 2'd1;
            end
            case (state)
                IDLE: begin
                    if (accept && is_mul_op) begin
                        state     <= MUL_RUN;
                        busy      <= 1'b1;
                        mul_stage <= '0;
                        mul_a     <= mdu_abs(a, op != MULTU);
                        mul_b     <= mdu_abs(b, op != MULTU);
                        mul_neg   <= (op != MULTU) & (a[31] ^ b[31]);
                        mul_only  <= (op == MUL);
                    end else if (div_start) begin
                        state <= DIV_RUN;
                        busy  <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    mul_stage <= mul_stage + 2'd1;
                    if (mul_stage == 2'd0) begin
                        pp_ll <= {16'b0, mul_a[15:0]}  * {16'b0, mul_b[15:0]};
                        pp_lh <= {16'b0, mul_a[15:0]}  * {16'b0, mul_b[31:16]};
                        pp_hl <= {16'b0, mul_a[31:16]} * {16'b0, mul_b[15:0]};
                        pp_hh <= {16'b0, mul_a[31:16]} * {16'b0, mul_b[31:16]};
                    end else if (mul_stage == 2'd1) begin
                        mul_prod <= mul_neg ? (~pp_sum + 64'd1) : pp_sum;
                    end
                    if (mul_last) begin
                        if (mul_only)
                            mul_result <= mul_prod[31:0];
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    if (div_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_core.sv
// Scoreboard bench for mdu_core: driver models each op arithmetically and queues the
// expected HI/LO/mul_result and busy length; a monitor checks each completion.
module tb_mdu_core;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic [3:0]  MDUOp;
    logic        start, mt_en, recover;
    logic [1:0]  recover_num;
    logic [31:0] highReg, lowReg, mul_result;
    logic        busy;

`ifdef MDU_DIV_ZERO_FAST_EN
    localparam bit FAST_DIV0 = 1'b1;
`else
    localparam bit FAST_DIV0 = 1'b0;
`endif

    mdu_core dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .MDUOp       (MDUOp),
        .start       (start),
        .mt_en       (mt_en),
        .highReg     (highReg),
        .lowReg      (lowReg),
        .mul_result  (mul_result),
        .busy        (busy),
        .recover     (recover),
        .recover_num (recover_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mr;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    logic [31:0] m_hi, m_lo, m_mr;
    logic [63:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_hist();
        m_hist.push_front({m_hi, m_lo});
        if (m_hist.size() > 2) void'(m_hist.pop_back());
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        wait_drain();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_mr = '0;
        m_hist.delete();
        check("reset_hi", highReg, 32'd0);
        check("reset_lo", lowReg, 32'd0);
        check("reset_mul_result", mul_result, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic imt, input int rec_at_in, input logic [1:0] rnum, input bit ghost);
        logic [31:0] s_hi, s_lo, s_mr;
        logic [63:0] s_hist[$];
        longint      sa, sb, p;
        longint unsigned ua, ub, up;
        int          si, ti, lat, rec_at, n;
        wait_idle();
        s_hi = m_hi; s_lo = m_lo; s_mr = m_mr; s_hist = m_hist;
        sa = longint'($signed(ia)); sb = longint'($signed(ib));
        ua = {32'b0, ia};          ub = {32'b0, ib};
        lat = 0;
        case (op)
            4'd1: begin p = sa * sb; push_hist(); {m_hi, m_lo} = p; lat = 3; end
            4'd2: begin up = ua * ub; push_hist(); {m_hi, m_lo} = up; lat = 3; end
            4'd3, 4'd4: begin
                push_hist();
                lat = 34;
                if (ib == 32'd0) begin
                    m_hi = ia; m_lo = 32'hFFFF_FFFF;
                    if (FAST_DIV0) lat = 0;
                end else if (op == 4'd3) begin
                    si = $signed(ia); ti = $signed(ib);
                    m_lo = si / ti; m_hi = si % ti;
                end else begin
                    m_lo = ia / ib; m_hi = ia % ib;
                end
            end
            4'd7: if (imt) begin push_hist(); m_hi = ia; end
            4'd8: if (imt) begin push_hist(); m_lo = ia; end
            4'd9: begin p = sa * sb; m_mr = p[31:0]; lat = 3; end
            default: ;
        endcase
        rec_at = (rec_at_in > lat) ? 0 : rec_at_in;
        exp_q.push_back('{m_hi, m_lo, m_mr, lat});
        a = ia; b = ib; MDUOp = op; mt_en = imt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (lat > 0 && (ghost || rec_at > 0)) begin
            for (int t = 1; t <= lat; t++) begin
                if (ghost && t == 1) begin
                    start = 1'b1; MDUOp = 4'($urandom_range(0, 15));
                    a = $urandom; b = $urandom; mt_en = 1'b1;
                end
                if (t == rec_at) begin
                    recover = 1'b1; recover_num = rnum;
                    m_hi = s_hi; m_lo = s_lo; m_mr = s_mr; m_hist = s_hist;
                    n = (rnum == 2'd3) ? 2 : int'(rnum);
                    if (n > m_hist.size()) n = m_hist.size();
                    repeat (n) {m_hi, m_lo} = m_hist.pop_front();
                    exp_q[exp_q.size() - 1] = '{m_hi, m_lo, m_mr, t};
                end
                @(posedge clk); #1;
                start = 1'b0; recover = 1'b0;
                if (t == rec_at || t >= 1 && !(rec_at > t)) break;
            end
        end
    endtask

    // Monitor: an accept seen before an edge opens a transaction; it completes on the first busy-low cycle.
    initial begin
        bit   pend, active;
        int   bcnt;
        exp_t e;
        pend = 0; active = 0; bcnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0; active = 0;
            end else begin
                if (pend) begin active = 1; bcnt = 0; pend = 0; end
                if (active) begin
                    if (busy) bcnt++;
                    else begin
                        active = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_completion", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("hi", highReg, e.hi);
                            check("lo", lowReg, e.lo);
                            check("mul_result", mul_result, e.mr);
                            check("busy_cycles", bcnt, e.lat);
                        end
                    end
                end
                if (start && !busy && !recover) pend = 1;
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'd0;
            1:       v = $urandom_range(1, 20);
            2:       v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; recover = 1'b0; recover_num = '0;
        a = '0; b = '0; MDUOp = '0; mt_en = 1'b0;
        m_hi = '0; m_lo = '0; m_mr = '0;
        @(posedge clk); #1;
        do_reset();

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 2'd0, 0);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 2'd0, 0);
        issue(4'd3, -32'sd7, 32'd2, 1'b0, 0, 2'd0, 0);
        issue(4'd4, 32'd100, 32'd0, 1'b0, 0, 2'd0, 0);
        do_reset();
        issue(4'd7, 32'h11, 32'd0, 1'b1, 0, 2'd0, 0);
        issue(4'd8, 32'h22, 32'd0, 1'b1, 0, 2'd0, 0);
        issue(4'd3, 32'd50, 32'd3, 1'b0, 10, 2'd1, 0);
        issue(4'd9, 32'd3, 32'd5, 1'b0, 0, 2'd0, 1);
        issue(4'd7, 32'h99, 32'd0, 1'b0, 0, 2'd0, 0);
        issue(4'd3, 32'h8000_0000, 32'd7, 1'b0, 34, 2'd1, 0);
        do_reset();
        issue(4'd7, 32'h5, 32'd0, 1'b1, 0, 2'd0, 0);
        issue(4'd1, 32'd7, 32'd9, 1'b0, 3, 2'd2, 0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            ra = rnd_operand(); rb = rnd_operand();
            if (op == 4'd3 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            issue(op, ra, rb, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
